// File: rtl/sw_input_conditioner.sv
// sw_input_conditioner
//   Input stage for the picoMips core. Synchronises the raw slide switches,
//   debounces the "enter" strobe and captures exactly one data byte per
//   physical press, then offers it to the core over a valid/ack handshake.
//
// Ports
//   Clock       in   system clock, all logic on posedge
//   Reset       in   synchronous, active-high reset
//   SW_data     in   raw switch data byte (asynchronous)
//   SW_strobe   in   raw enter switch (asynchronous, bouncy)
//   data_out    out  captured byte, stable while data_valid is high
//   data_valid  out  data_out holds an unconsumed byte
//   data_ack    in   core consumed data_out (ignored unless data_valid)
module sw_input_conditioner #(
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] SW_data,
  input  logic              SW_strobe,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ack
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESS   = 2'd1,
    S_VALID   = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0]             strobe_sync_q, strobe_sync_d;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] data_sync_q, data_sync_d;
  logic                               strobe_s;
  logic [DATA_W-1:0]                  data_s;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;

  // Synchroniser shift chains; index 0 is the first stage.
  always_comb begin
    strobe_sync_d = {strobe_sync_q[SYNC_STAGES-2:0], SW_strobe};
    data_sync_d   = {data_sync_q[SYNC_STAGES-2:0], SW_data};
    strobe_s      = strobe_sync_q[SYNC_STAGES-1];
    data_s        = data_sync_q[SYNC_STAGES-1];
  end

  // Debounce / capture / handshake FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;

    case (state_q)
      S_IDLE: begin
        // The sample that triggers the move already counts as the first.
        if (strobe_s) begin
          state_d = S_PRESS;
          cnt_d   = CNT_ONE;
        end
      end

      S_PRESS: begin
        if (!strobe_s) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = S_VALID;
          cnt_d        = '0;
          data_out_d   = data_s;
          data_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_VALID: begin
        // Strobe is ignored here: no overwrite, no queueing.
        if (data_ack) begin
          state_d      = S_RELEASE;
          cnt_d        = '0;
          data_valid_d = 1'b0;
        end
      end

      S_RELEASE: begin
        // Re-arm only after a full run of stable-low samples.
        if (strobe_s) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d      = S_RELEASE;
        cnt_d        = '0;
        data_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset lands in RELEASE so a strobe held
  // through reset is not treated as a press.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      strobe_sync_q <= '0;
      data_sync_q   <= '0;
      state_q       <= S_RELEASE;
      cnt_q         <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
    end else begin
      strobe_sync_q <= strobe_sync_d;
      data_sync_q   <= data_sync_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

endmodule
